// File: rtl/silife_grid_engine_if.sv
`default_nettype none
// ============================================================================
// Module   : silife_grid_engine_if
// Purpose  : Control, row-access and status bundle of the Game-of-Life engine.
//            The master drives control and write data; the slave (the engine)
//            returns read data, the generation count and status flags.
// Revision : 1.0 - initial release
// ============================================================================
interface silife_grid_engine_if #(
  parameter int WIDTH  = 8,
  parameter int HEIGHT = 8,
  parameter int GEN_W  = 16,
  parameter int ROW_W  = (HEIGHT > 1) ? $clog2(HEIGHT) : 1
);
  logic             run;
  logic             step;
  logic             stop_on_stable;
  logic             wrap_en;
  logic             wr_en;
  logic [ROW_W-1:0] row_sel;
  logic [WIDTH-1:0] wr_data;
  logic             clr_gen;
  logic [WIDTH-1:0] rd_data;
  logic [GEN_W-1:0] gen_count;
  logic             stable;
  logic             extinct;
  logic             halted;

  modport master (
    output run, step, stop_on_stable, wrap_en, wr_en, row_sel, wr_data, clr_gen,
    input  rd_data, gen_count, stable, extinct, halted
  );

  modport slave (
    input  run, step, stop_on_stable, wrap_en, wr_en, row_sel, wr_data, clr_gen,
    output rd_data, gen_count, stable, extinct, halted
  );
endinterface
`default_nettype wire

// File: rtl/silife_grid_engine.sv
`default_nettype none
// ============================================================================
// Module   : silife_grid_engine
// Purpose  : WIDTH x HEIGHT Game-of-Life array (B3/S23) with row read/write,
//            selectable toroidal or dead-border neighbourhood, single-step,
//            free-run and stop-on-stable modes, generation counter and
//            stable/extinct status.
// Revision : 1.0 - initial release
// ============================================================================
module silife_grid_engine #(
  parameter int WIDTH  = 8,
  parameter int HEIGHT = 8,
  parameter int GEN_W  = 16,
  parameter int ROW_W  = (HEIGHT > 1) ? $clog2(HEIGHT) : 1
) (
  input  wire logic          clk,
  input  wire logic          rst_n,
  silife_grid_engine_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_RUN    = 2'd1,
    S_HALTED = 2'd2
  } state_t;

  // Row count widened by one bit so a power-of-two HEIGHT still compares correctly.
  localparam logic [ROW_W:0] c_rows = (ROW_W+1)'(HEIGHT);

  state_t                         r_state;
  logic                           r_halted;
  logic [HEIGHT-1:0][WIDTH-1:0]   r_cells;
  logic [WIDTH-1:0]               r_rd_data;
  logic [GEN_W-1:0]               r_gen;
  logic                           r_stable;
  logic                           r_extinct;

  logic [HEIGHT-1:0][WIDTH-1:0]   w_next;
  logic [HEIGHT-1:0][WIDTH-1:0]   w_upd;
  logic                           w_row_ok;
  logic                           w_wr_ok;
  logic                           w_tick;
  logic                           w_same;

  assign w_row_ok = ({1'b0, bus.row_sel} < c_rows);
  assign w_wr_ok  = bus.wr_en & w_row_ok;
  // Any write request, even to a non-existent row, defers the generation.
  assign w_tick   = ((r_state == S_IDLE) & bus.step | (r_state == S_RUN)) & ~bus.wr_en;
  assign w_same   = (w_next == r_cells);

  // Next-generation logic. Column 0 lives in bit WIDTH-1, so the left
  // neighbour of bit b is bit b+1 and the right neighbour is bit b-1.
  for (genvar r = 0; r < HEIGHT; r++) begin : g_row
    for (genvar b = 0; b < WIDTH; b++) begin : g_col
      localparam int  c_up    = (r == 0)          ? HEIGHT - 1 : r - 1;
      localparam int  c_dn    = (r == HEIGHT - 1) ? 0          : r + 1;
      localparam int  c_lt    = (b == WIDTH - 1)  ? 0          : b + 1;
      localparam int  c_rt    = (b == 0)          ? WIDTH - 1  : b - 1;
      localparam bit  c_top   = (r == 0);
      localparam bit  c_bot   = (r == HEIGHT - 1);
      localparam bit  c_left  = (b == WIDTH - 1);
      localparam bit  c_right = (b == 0);

      logic       w_up_ok;
      logic       w_dn_ok;
      logic       w_lt_ok;
      logic       w_rt_ok;
      logic [7:0] w_nb;
      logic [3:0] w_cnt;

      // Edge neighbours exist only when wrapping is enabled.
      assign w_up_ok = bus.wrap_en | ~c_top;
      assign w_dn_ok = bus.wrap_en | ~c_bot;
      assign w_lt_ok = bus.wrap_en | ~c_left;
      assign w_rt_ok = bus.wrap_en | ~c_right;

      assign w_nb = {
        r_cells[c_up][c_lt] & w_up_ok & w_lt_ok,
        r_cells[c_up][b]    & w_up_ok,
        r_cells[c_up][c_rt] & w_up_ok & w_rt_ok,
        r_cells[r][c_lt]    & w_lt_ok,
        r_cells[r][c_rt]    & w_rt_ok,
        r_cells[c_dn][c_lt] & w_dn_ok & w_lt_ok,
        r_cells[c_dn][b]    & w_dn_ok,
        r_cells[c_dn][c_rt] & w_dn_ok & w_rt_ok
      };

      assign w_cnt = 4'($countones(w_nb));
      assign w_next[r][b] = (w_cnt == 4'd3) | (r_cells[r][b] & (w_cnt == 4'd2));
    end
  end

  // Array contents after this edge: a write beats a generation step.
  always_comb begin
    w_upd = r_cells;
    if (w_wr_ok) begin
      w_upd[bus.row_sel] = bus.wr_data;
    end else if (w_tick) begin
      w_upd = w_next;
    end
  end

  // Cell array, read port, generation counter and status flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cells   <= '0;
      r_rd_data <= '0;
      r_gen     <= '0;
      r_stable  <= 1'b0;
      r_extinct <= 1'b1;
    end else begin
      r_cells   <= w_upd;
      r_extinct <= (w_upd == '0);
      r_rd_data <= w_row_ok ? r_cells[bus.row_sel] : '0;
      if (bus.clr_gen) begin
        r_gen <= '0;
      end else if (w_tick) begin
        r_gen <= r_gen + GEN_W'(1);
      end
      if (w_wr_ok) begin
        r_stable <= 1'b0;
      end else if (w_tick) begin
        r_stable <= w_same;
      end
    end
  end

  // Mode control: IDLE / RUN / HALTED with a registered halted flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= S_IDLE;
      r_halted <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_halted <= 1'b0;
          if (bus.run) begin
            r_state <= S_RUN;
          end
        end
        S_RUN: begin
          if (!bus.run) begin
            r_state  <= S_IDLE;
            r_halted <= 1'b0;
          end else if (w_tick && bus.stop_on_stable && w_same) begin
            r_state  <= S_HALTED;
            r_halted <= 1'b1;
          end
        end
        S_HALTED: begin
          if (!bus.run) begin
            r_state  <= S_IDLE;
            r_halted <= 1'b0;
          end else if (w_wr_ok) begin
            r_state  <= S_RUN;
            r_halted <= 1'b0;
          end
        end
        default: begin
          r_state  <= S_IDLE;
          r_halted <= 1'b0;
        end
      endcase
    end
  end

  assign bus.rd_data   = r_rd_data;
  assign bus.gen_count = r_gen;
  assign bus.stable    = r_stable;
  assign bus.extinct   = r_extinct;
  assign bus.halted    = r_halted;

endmodule
`default_nettype wire

// File: tb/tb_silife_grid_engine.sv
`default_nettype none
// ============================================================================
// Module   : tb_silife_grid_engine
// Purpose  : Directed self-checking bench for silife_grid_engine (8x8 build
//            plus a 5-row build for out-of-range row handling).
// Revision : 1.0 - initial release
// ============================================================================
module tb_silife_grid_engine;

  logic clk;
  logic rst_n;
  int   total;
  int   bad;

  silife_grid_engine_if #(.WIDTH(8), .HEIGHT(8), .GEN_W(16), .ROW_W(3)) bus ();
  silife_grid_engine_if #(.WIDTH(8), .HEIGHT(5), .GEN_W(16), .ROW_W(3)) bus5 ();

  silife_grid_engine #(.WIDTH(8), .HEIGHT(8), .GEN_W(16), .ROW_W(3)) u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  silife_grid_engine #(.WIDTH(8), .HEIGHT(5), .GEN_W(16), .ROW_W(3)) u_dut5 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus5)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wr_row(input logic [2:0] r, input logic [7:0] d);
    bus.wr_en   = 1'b1;
    bus.row_sel = r;
    bus.wr_data = d;
    @(negedge clk);
    bus.wr_en   = 1'b0;
  endtask

  task automatic chk_row(input string tag, input logic [2:0] r, input logic [7:0] exp);
    bus.row_sel = r;
    @(negedge clk);
    chk(tag, 32'(bus.rd_data), 32'(exp));
  endtask

  task automatic step1();
    bus.step = 1'b1;
    @(negedge clk);
    bus.step = 1'b0;
  endtask

  // run high for n clocks, then low for one: exactly n generations.
  task automatic run_gens(input int n);
    bus.run = 1'b1;
    repeat (n) @(negedge clk);
    bus.run = 1'b0;
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic load_glider();
    wr_row(3'd0, 8'h40);
    wr_row(3'd1, 8'h20);
    wr_row(3'd2, 8'hE0);
  endtask

  initial begin
    logic [7:0] glider [8];
    total = 0;
    bad   = 0;
    glider = '{8'h40, 8'h20, 8'hE0, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};

    rst_n = 1'b0;
    bus.run = 0; bus.step = 0; bus.stop_on_stable = 0; bus.wrap_en = 0;
    bus.wr_en = 0; bus.row_sel = '0; bus.wr_data = '0; bus.clr_gen = 0;
    bus5.run = 0; bus5.step = 0; bus5.stop_on_stable = 0; bus5.wrap_en = 0;
    bus5.wr_en = 0; bus5.row_sel = '0; bus5.wr_data = '0; bus5.clr_gen = 0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Reset state
    chk("rst_gen",     32'(bus.gen_count), 32'd0);
    chk("rst_stable",  32'(bus.stable),    32'd0);
    chk("rst_extinct", 32'(bus.extinct),   32'd1);
    chk("rst_halted",  32'(bus.halted),    32'd0);
    chk("rst_rd",      32'(bus.rd_data),   32'd0);

    // Blinker, dead border
    bus.wrap_en = 1'b0;
    wr_row(3'd3, 8'h10);
    wr_row(3'd4, 8'h10);
    wr_row(3'd5, 8'h10);
    chk("blk_extinct0", 32'(bus.extinct), 32'd0);
    step1();
    chk("blk_gen1", 32'(bus.gen_count), 32'd1);
    chk_row("blk_r3", 3'd3, 8'h00);
    chk_row("blk_r4", 3'd4, 8'h38);
    chk_row("blk_r5", 3'd5, 8'h00);
    step1();
    chk("blk_gen2",    32'(bus.gen_count), 32'd2);
    chk("blk_stable2", 32'(bus.stable),    32'd0);
    chk_row("blk_r3b", 3'd3, 8'h10);
    chk_row("blk_r4b", 3'd4, 8'h10);

    // Glider on the torus returns home after 32 generations
    do_reset();
    bus.wrap_en = 1'b1;
    load_glider();
    run_gens(32);
    chk("tor_gen",    32'(bus.gen_count), 32'd32);
    chk("tor_halted", 32'(bus.halted),    32'd0);
    for (int i = 0; i < 8; i++) begin
      chk_row($sformatf("tor_r%0d", i), 3'(i), glider[i]);
    end

    // Same glider with a dead border settles into a corner block
    do_reset();
    bus.wrap_en = 1'b0;
    load_glider();
    run_gens(32);
    chk("dead_gen",    32'(bus.gen_count), 32'd32);
    chk("dead_stable", 32'(bus.stable),    32'd1);
    chk_row("dead_r0", 3'd0, 8'h00);
    chk_row("dead_r5", 3'd5, 8'h00);
    chk_row("dead_r6", 3'd6, 8'h03);
    chk_row("dead_r7", 3'd7, 8'h03);

    // Stop-on-stable with a still-life block
    do_reset();
    bus.stop_on_stable = 1'b1;
    wr_row(3'd3, 8'h18);
    wr_row(3'd4, 8'h18);
    bus.run = 1'b1;
    @(negedge clk);
    chk("sos_halted_early", 32'(bus.halted), 32'd0);
    @(negedge clk);
    chk("sos_halted", 32'(bus.halted),    32'd1);
    chk("sos_gen",    32'(bus.gen_count), 32'd1);
    chk("sos_stable", 32'(bus.stable),    32'd1);
    repeat (3) @(negedge clk);
    step1();
    chk("sos_gen_hold", 32'(bus.gen_count), 32'd1);
    chk_row("sos_r3", 3'd3, 8'h18);
    wr_row(3'd0, 8'h80);
    chk("sos_resume",  32'(bus.halted), 32'd0);
    chk("sos_wr_stab", 32'(bus.stable), 32'd0);
    bus.run = 1'b0;
    bus.stop_on_stable = 1'b0;
    @(negedge clk);

    // Write during RUN defers the generation
    do_reset();
    bus.run = 1'b1;
    @(negedge clk);
    bus.wr_en = 1'b1;
    bus.row_sel = 3'd2;
    bus.wr_data = 8'hF0;
    @(negedge clk);
    chk("wrrun_gen0", 32'(bus.gen_count), 32'd0);
    bus.wr_en = 1'b0;
    bus.run = 1'b0;
    @(negedge clk);
    chk("wrrun_rd",   32'(bus.rd_data),   32'hF0);
    chk("wrrun_gen1", 32'(bus.gen_count), 32'd1);
    chk_row("wrrun_r1", 3'd1, 8'h60);
    chk_row("wrrun_r2", 3'd2, 8'h60);
    chk_row("wrrun_r3", 3'd3, 8'h60);

    // Five-row build: rows 5..7 do not exist
    bus5.step = 1'b1;
    @(negedge clk);
    bus5.step = 1'b0;
    chk("h5_gen",     32'(bus5.gen_count), 32'd1);
    chk("h5_stable1", 32'(bus5.stable),    32'd1);
    bus5.wr_en = 1'b1; bus5.row_sel = 3'd5; bus5.wr_data = 8'h5A;
    @(negedge clk);
    bus5.wr_en = 1'b0;
    chk("h5_bad_wr_stable", 32'(bus5.stable),  32'd1);
    chk("h5_bad_wr_ext",    32'(bus5.extinct), 32'd1);
    @(negedge clk);
    chk("h5_rd_row5", 32'(bus5.rd_data), 32'd0);
    bus5.wr_en = 1'b1; bus5.row_sel = 3'd4; bus5.wr_data = 8'hA5;
    @(negedge clk);
    bus5.wr_en = 1'b0;
    chk("h5_wr_stable", 32'(bus5.stable), 32'd0);
    @(negedge clk);
    chk("h5_rd_row4", 32'(bus5.rd_data), 32'hA5);
    bus5.row_sel = 3'd0;
    @(negedge clk);
    chk("h5_rd_row0", 32'(bus5.rd_data), 32'd0);

    // Lone cell dies
    do_reset();
    wr_row(3'd3, 8'h08);
    chk("one_extinct0", 32'(bus.extinct), 32'd0);
    step1();
    chk("one_extinct1", 32'(bus.extinct),   32'd1);
    chk("one_gen",      32'(bus.gen_count), 32'd1);
    chk_row("one_r3", 3'd3, 8'h00);

    // clr_gen beats a simultaneous step
    bus.step = 1'b1;
    bus.clr_gen = 1'b1;
    @(negedge clk);
    bus.step = 1'b0;
    bus.clr_gen = 1'b0;
    chk("clr_gen", 32'(bus.gen_count), 32'd0);

    // Asynchronous reset in the middle of a run
    bus.wrap_en = 1'b1;
    load_glider();
    bus.row_sel = 3'd2;
    bus.run = 1'b1;
    repeat (5) @(negedge clk);
    chk("arst_pre_gen", 32'(bus.gen_count), 32'd4);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_gen",     32'(bus.gen_count), 32'd0);
    chk("arst_extinct", 32'(bus.extinct),   32'd1);
    chk("arst_stable",  32'(bus.stable),    32'd0);
    chk("arst_halted",  32'(bus.halted),    32'd0);
    chk("arst_rd",      32'(bus.rd_data),   32'd0);
    bus.run = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk_row("arst_r2", 3'd2, 8'h00);
    chk("arst_gen_after", 32'(bus.gen_count), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
